// File: rtl/chess_pkg.sv
// Shared types, button bit positions, default board geometry and the cursor
// clamp helper for the mouse-driven move selector.
package chess_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SRC_SEL,
        WAIT_ACK
    } sel_state_t;

    typedef logic [5:0] square_t;

    localparam int BTN_LEFT  = 0;
    localparam int BTN_RIGHT = 1;

    localparam int BOARD_X0 = 80;
    localparam int BOARD_Y0 = 0;
    localparam int SQ_SIZE  = 60;

    // Registered hover mapping of the centre-screen reset cursor (320,240).
    localparam logic    HOVER_RST_VALID = 1'b1;
    localparam square_t HOVER_RST_SQ    = 6'd28;

    // Add a signed 8-bit displacement to an axis position and clamp to 0..limit-1.
    function automatic logic [9:0] clamp_axis(input logic [9:0] pos,
                                              input logic [7:0] disp,
                                              input int         limit);
        logic signed [10:0] nxt;
        nxt = $signed({1'b0, pos}) + $signed({{3{disp[7]}}, disp});
        if (nxt[10])
            return '0;
        if (nxt > $signed(11'(limit - 1)))
            return 10'(limit - 1);
        return nxt[9:0];
    endfunction

endpackage

// File: rtl/mouse_cursor_select_if.sv
// Move-request handshake toward the downstream move-validation logic.
interface mouse_cursor_select_if;
    import chess_pkg::*;

    logic    move_valid;
    logic    move_ready;
    square_t move_src;
    square_t move_dst;

    modport master (output move_valid, output move_src, output move_dst, input move_ready);
    modport slave  (input move_valid, input move_src, input move_dst, output move_ready);

endinterface

// File: rtl/board_square_map.sv
// Combinational pixel to chessboard square mapping using a threshold compare
// chain per axis instead of a divider.
module board_square_map
    import chess_pkg::*;
#(
    parameter int BOARD_X0 = chess_pkg::BOARD_X0,
    parameter int BOARD_Y0 = chess_pkg::BOARD_Y0,
    parameter int SQ_SIZE  = chess_pkg::SQ_SIZE
) (
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    output logic       valid,
    output square_t    sq
);

    logic [11:0] off_x;
    logic [11:0] off_y;
    logic [2:0]  file;
    logic [2:0]  row;
    logic        in_x;
    logic        in_y;

    // Offsets go negative (bit 11 set) left of / above the board.
    always_comb begin
        off_x = {2'b00, pix_x} - 12'(BOARD_X0);
        off_y = {2'b00, pix_y} - 12'(BOARD_Y0);
        in_x  = ~off_x[11] && (off_x[10:0] < 11'(8 * SQ_SIZE));
        in_y  = ~off_y[11] && (off_y[10:0] < 11'(8 * SQ_SIZE));
        file  = '0;
        row   = '0;
        for (int unsigned i = 1; i < 8; i++) begin
            if (off_x[10:0] >= 11'(i * SQ_SIZE))
                file = file + 3'd1;
            if (off_y[10:0] >= 11'(i * SQ_SIZE))
                row = row + 3'd1;
        end
        valid = in_x && in_y;
        sq    = {3'd7 - row, file};
    end

endmodule

// File: rtl/mouse_cursor_select.sv
// Mouse reports -> clamped cursor -> board hover square -> two-click
// source/destination select FSM driving a valid/ready move request.
module mouse_cursor_select
    import chess_pkg::*;
#(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int BOARD_X0 = chess_pkg::BOARD_X0,
    parameter int BOARD_Y0 = chess_pkg::BOARD_Y0,
    parameter int SQ_SIZE  = chess_pkg::SQ_SIZE
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          report_valid,
    input  logic [7:0]                    x_disp,
    input  logic [7:0]                    y_disp,
    input  logic [7:0]                    button_status,
    mouse_cursor_select_if.master         move_bus,
    output logic [9:0]                    cursor_x,
    output logic [9:0]                    cursor_y,
    output logic                          hover_valid,
    output square_t                       hover_sq,
    output logic                          sel_valid,
    output square_t                       sel_sq
);

    logic [1:0] prev_btn;
    logic       left_rise;
    logic       right_rise;
    logic       map_valid;
    square_t    map_sq;
    logic       unused_btn;

    sel_state_t state, state_n;
    logic       sel_valid_n;
    square_t    sel_sq_n;
    logic       move_valid_q, move_valid_n;
    square_t    move_src_q, move_src_n;
    square_t    move_dst_q, move_dst_n;

    assign unused_btn = ^button_status[7:2];

    // Stage 1: cursor integration and button edge capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cursor_x   <= 10'(SCREEN_W / 2);
            cursor_y   <= 10'(SCREEN_H / 2);
            prev_btn   <= '0;
            left_rise  <= 1'b0;
            right_rise <= 1'b0;
        end else if (report_valid) begin
            cursor_x   <= clamp_axis(cursor_x, x_disp, SCREEN_W);
            cursor_y   <= clamp_axis(cursor_y, y_disp, SCREEN_H);
            left_rise  <= button_status[BTN_LEFT]  & ~prev_btn[BTN_LEFT];
            right_rise <= button_status[BTN_RIGHT] & ~prev_btn[BTN_RIGHT];
            prev_btn   <= button_status[1:0];
        end else begin
            left_rise  <= 1'b0;
            right_rise <= 1'b0;
        end
    end

    board_square_map #(
        .BOARD_X0 (BOARD_X0),
        .BOARD_Y0 (BOARD_Y0),
        .SQ_SIZE  (SQ_SIZE)
    ) u_map (
        .pix_x (cursor_x),
        .pix_y (cursor_y),
        .valid (map_valid),
        .sq    (map_sq)
    );

    // Stage 2: hover registers and select FSM share the freshly mapped square.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hover_valid  <= HOVER_RST_VALID;
            hover_sq     <= HOVER_RST_SQ;
            state        <= IDLE;
            sel_valid    <= 1'b0;
            sel_sq       <= '0;
            move_valid_q <= 1'b0;
            move_src_q   <= '0;
            move_dst_q   <= '0;
        end else begin
            hover_valid  <= map_valid;
            hover_sq     <= map_sq;
            state        <= state_n;
            sel_valid    <= sel_valid_n;
            sel_sq       <= sel_sq_n;
            move_valid_q <= move_valid_n;
            move_src_q   <= move_src_n;
            move_dst_q   <= move_dst_n;
        end
    end

    always_comb begin
        state_n      = state;
        sel_valid_n  = sel_valid;
        sel_sq_n     = sel_sq;
        move_valid_n = move_valid_q;
        move_src_n   = move_src_q;
        move_dst_n   = move_dst_q;
        case (state)
            IDLE: begin
                if (!right_rise && left_rise && map_valid) begin
                    sel_sq_n    = map_sq;
                    sel_valid_n = 1'b1;
                    state_n     = SRC_SEL;
                end
            end
            SRC_SEL: begin
                if (right_rise) begin
                    sel_valid_n = 1'b0;
                    state_n     = IDLE;
                end else if (left_rise) begin
                    sel_valid_n = 1'b0;
                    if (map_valid && map_sq != sel_sq) begin
                        move_src_n   = sel_sq;
                        move_dst_n   = map_sq;
                        move_valid_n = 1'b1;
                        state_n      = WAIT_ACK;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            WAIT_ACK: begin
                if (move_bus.move_ready) begin
                    move_valid_n = 1'b0;
                    state_n      = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign move_bus.move_valid = move_valid_q;
    assign move_bus.move_src   = move_src_q;
    assign move_bus.move_dst   = move_dst_q;

endmodule

// File: tb/tb_mouse_cursor_select.sv
// Scoreboard bench: stimulus queues expected snapshots and move transfers,
// a negedge monitor pops and compares them against the DUT.
module tb_mouse_cursor_select;
    import chess_pkg::*;

    typedef struct {
        int due;
        int cx, cy, hv, hsq, sv, ssq, mv, ms, md;
    } snap_t;

    typedef struct {
        int src, dst;
    } mv_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       report_valid = 1'b0;
    logic [7:0] x_disp = '0;
    logic [7:0] y_disp = '0;
    logic [7:0] button_status = '0;
    logic [9:0] cursor_x, cursor_y;
    logic       hover_valid, sel_valid;
    square_t    hover_sq, sel_sq;

    int    cyc = 0;
    int    total = 0;
    int    bad = 0;
    snap_t exp_q[$];
    mv_t   mv_q[$];
    snap_t e;
    mv_t   m;

    mouse_cursor_select_if bus ();

    mouse_cursor_select dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .report_valid  (report_valid),
        .x_disp        (x_disp),
        .y_disp        (y_disp),
        .button_status (button_status),
        .move_bus      (bus.master),
        .cursor_x      (cursor_x),
        .cursor_y      (cursor_y),
        .hover_valid   (hover_valid),
        .hover_sq      (hover_sq),
        .sel_valid     (sel_valid),
        .sel_sq        (sel_sq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: snapshot scoreboard plus move-transfer scoreboard.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            total++;
            if (e.due != cyc || cursor_x != 10'(e.cx) || cursor_y != 10'(e.cy) ||
                hover_valid != 1'(e.hv) || (e.hv != 0 && hover_sq != 6'(e.hsq)) ||
                sel_valid != 1'(e.sv) || (e.sv != 0 && sel_sq != 6'(e.ssq)) ||
                bus.move_valid != 1'(e.mv) ||
                (e.mv != 0 && (bus.move_src != 6'(e.ms) || bus.move_dst != 6'(e.md)))) begin
                bad++;
                $display("FAIL snap cyc=%0d due=%0d: got x=%0d y=%0d hv=%0d hsq=%0d sv=%0d ssq=%0d mv=%0d src=%0d dst=%0d; want x=%0d y=%0d hv=%0d hsq=%0d sv=%0d ssq=%0d mv=%0d src=%0d dst=%0d",
                         cyc, e.due, cursor_x, cursor_y, hover_valid, hover_sq, sel_valid, sel_sq,
                         bus.move_valid, bus.move_src, bus.move_dst,
                         e.cx, e.cy, e.hv, e.hsq, e.sv, e.ssq, e.mv, e.ms, e.md);
            end
        end
        if (reset_n && bus.move_valid && bus.move_ready) begin
            total++;
            if (mv_q.size() == 0) begin
                bad++;
                $display("FAIL move_xfer: got unexpected src=%0d dst=%0d; want no transfer",
                         bus.move_src, bus.move_dst);
            end else begin
                m = mv_q.pop_front();
                if (bus.move_src != 6'(m.src) || bus.move_dst != 6'(m.dst)) begin
                    bad++;
                    $display("FAIL move_xfer: got src=%0d dst=%0d; want src=%0d dst=%0d",
                             bus.move_src, bus.move_dst, m.src, m.dst);
                end
            end
        end
    end

    task automatic report(input int dx, input int dy, input logic [7:0] btn);
        @(posedge clk);
        #1;
        report_valid  = 1'b1;
        x_disp        = 8'(dx);
        y_disp        = 8'(dy);
        button_status = btn;
        @(posedge clk);
        #1;
        report_valid  = 1'b0;
        x_disp        = '0;
        y_disp        = '0;
    endtask

    task automatic exp_s(input int dly, input int cx, input int cy, input int hv, input int hsq,
                         input int sv, input int ssq, input int mv, input int ms = 0,
                         input int md = 0);
        snap_t s;
        s.due = cyc + dly;
        s.cx = cx; s.cy = cy; s.hv = hv; s.hsq = hsq;
        s.sv = sv; s.ssq = ssq; s.mv = mv; s.ms = ms; s.md = md;
        exp_q.push_back(s);
    endtask

    // One report followed by the state expected two cycles after it.
    task automatic rep_chk(input int dx, input int dy, input logic [7:0] btn, input int cx,
                           input int cy, input int hv, input int hsq, input int sv,
                           input int ssq, input int mv = 0, input int ms = 0, input int md = 0);
        report(dx, dy, btn);
        exp_s(1, cx, cy, hv, hsq, sv, ssq, mv, ms, md);
    endtask

    initial begin
        bus.move_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        exp_s(0, 320, 240, 1, 28, 0, 0, 0);

        // Right-edge clamp, then left-edge clamp, then top clamp.
        rep_chk(127, 0, 8'h00, 447, 240, 1, 30, 0, 0);
        rep_chk(127, 0, 8'h00, 574, 240, 0, 0, 0, 0);
        rep_chk(127, 0, 8'h00, 639, 240, 0, 0, 0, 0);
        rep_chk(127, 0, 8'h00, 639, 240, 0, 0, 0, 0);
        rep_chk(127, 0, 8'h00, 639, 240, 0, 0, 0, 0);
        rep_chk(-128, 0, 8'h00, 511, 240, 1, 31, 0, 0);
        rep_chk(-128, 0, 8'h00, 383, 240, 1, 29, 0, 0);
        rep_chk(-128, 0, 8'h00, 255, 240, 1, 26, 0, 0);
        rep_chk(-128, 0, 8'h00, 127, 240, 1, 24, 0, 0);
        rep_chk(-128, 0, 8'h00, 0, 240, 0, 0, 0, 0);
        rep_chk(-128, 0, 8'h00, 0, 240, 0, 0, 0, 0);
        rep_chk(0, -128, 8'h00, 0, 112, 0, 0, 0, 0);
        rep_chk(0, -128, 8'h00, 0, 0, 0, 0, 0, 0);
        rep_chk(127, 0, 8'h00, 127, 0, 1, 56, 0, 0);
        rep_chk(127, 0, 8'h00, 254, 0, 1, 58, 0, 0);
        rep_chk(66, 0, 8'h00, 320, 0, 1, 60, 0, 0);
        rep_chk(0, 127, 8'h00, 320, 127, 1, 44, 0, 0);
        rep_chk(0, 113, 8'h00, 320, 240, 1, 28, 0, 0);

        // Select 28, hold, release, move to 36, click -> move 28->36.
        rep_chk(0, 0, 8'h01, 320, 240, 1, 28, 1, 28);
        rep_chk(0, 0, 8'h01, 320, 240, 1, 28, 1, 28);
        rep_chk(0, 0, 8'h00, 320, 240, 1, 28, 1, 28);
        rep_chk(0, -60, 8'h00, 320, 180, 1, 36, 1, 28);
        report(0, 0, 8'h01);
        for (int i = 1; i <= 3; i++) exp_s(i, 320, 180, 1, 36, 0, 0, 1, 28, 36);
        exp_s(4, 320, 180, 1, 36, 0, 0, 0);
        mv_q.push_back('{src: 28, dst: 36});
        repeat (3) @(posedge clk);
        #1 bus.move_ready = 1'b1;
        @(posedge clk);
        #1 bus.move_ready = 1'b0;

        // Re-click same square, right-click cancel, simultaneous left+right.
        rep_chk(0, 0, 8'h00, 320, 180, 1, 36, 0, 0);
        rep_chk(0, 60, 8'h00, 320, 240, 1, 28, 0, 0);
        rep_chk(0, 0, 8'h01, 320, 240, 1, 28, 1, 28);
        rep_chk(0, 0, 8'h00, 320, 240, 1, 28, 1, 28);
        rep_chk(0, 0, 8'h01, 320, 240, 1, 28, 0, 0);
        rep_chk(0, 0, 8'h00, 320, 240, 1, 28, 0, 0);
        rep_chk(0, 0, 8'h01, 320, 240, 1, 28, 1, 28);
        rep_chk(0, 0, 8'h02, 320, 240, 1, 28, 0, 0);
        rep_chk(0, 0, 8'h00, 320, 240, 1, 28, 0, 0);
        rep_chk(0, 0, 8'h01, 320, 240, 1, 28, 1, 28);
        rep_chk(0, 0, 8'h00, 320, 240, 1, 28, 1, 28);
        rep_chk(0, 0, 8'h03, 320, 240, 1, 28, 0, 0);
        rep_chk(0, 0, 8'h00, 320, 240, 1, 28, 0, 0);

        // Off-board click, then motion+click resolving on the moved position.
        rep_chk(-128, 0, 8'h00, 192, 240, 1, 25, 0, 0);
        rep_chk(-128, 0, 8'h00, 64, 240, 0, 0, 0, 0);
        rep_chk(-24, 0, 8'h00, 40, 240, 0, 0, 0, 0);
        rep_chk(0, 0, 8'h01, 40, 240, 0, 0, 0, 0);
        rep_chk(0, 0, 8'h00, 40, 240, 0, 0, 0, 0);
        rep_chk(80, 0, 8'h00, 120, 240, 1, 24, 0, 0);
        rep_chk(-40, 0, 8'h01, 80, 240, 1, 24, 1, 24);
        rep_chk(0, 0, 8'h00, 80, 240, 1, 24, 1, 24);
        rep_chk(60, 0, 8'h00, 140, 240, 1, 25, 1, 24);
        rep_chk(0, 0, 8'h01, 140, 240, 1, 25, 0, 0, 1, 24, 25);

        // Clicks ignored while waiting for acceptance; cursor still tracks.
        rep_chk(0, 0, 8'h00, 140, 240, 1, 25, 0, 0, 1, 24, 25);
        rep_chk(-60, 0, 8'h01, 80, 240, 1, 24, 0, 0, 1, 24, 25);

        // Asynchronous reset mid-handshake, between clock edges.
        @(posedge clk);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (bus.move_valid !== 1'b0 || sel_valid !== 1'b0 || cursor_x !== 10'd320 ||
            cursor_y !== 10'd240 || hover_valid !== 1'b1 || hover_sq !== 6'd28) begin
            bad++;
            $display("FAIL async_reset: got mv=%0d sv=%0d x=%0d y=%0d hv=%0d hsq=%0d; want mv=0 sv=0 x=320 y=240 hv=1 hsq=28",
                     bus.move_valid, sel_valid, cursor_x, cursor_y, hover_valid, hover_sq);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        exp_s(0, 320, 240, 1, 28, 0, 0, 0);
        rep_chk(0, -60, 8'h00, 320, 180, 1, 36, 0, 0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending snapshots; want 0", exp_q.size());
        end
        if (mv_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL move_drain: got %0d untransferred moves; want 0", mv_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
